clockworks: RTL and testbench



---
 rtl/clockworks.sv | 88 ++++++++
 tb/tb_clockworks.sv | 117 +++++++++++
 2 files changed

// File: rtl/clockworks.sv
// Board clock divider and reset conditioner: CLK / 2^SLOW -> clk, RESET button -> clean core reset.
// Define CLOCKWORKS_BYPASS_EN to skip the divider (clk = CLK) for faster simulation.
module clockworks #(
    parameter int SLOW       = 24,
    parameter int RST_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic reset
);

`ifdef CLOCKWORKS_BYPASS_EN
    localparam bit DIRECT = 1'b1;
`else
    localparam bit DIRECT = (SLOW == 0);
`endif

    logic [1:0] sync_q, sync_d;
    logic [7:0] rel_cnt_q, rel_cnt_d;
    logic       done_q, done_d;
    logic       tick;

    always_comb sync_d = {sync_q[0], 1'b1};

    // NOTE: async clear on the button so even a sub-cycle pulse wipes the synchronizer.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    // The first tick after release aligns to a clk period; then count RST_CYCLES full periods.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        rel_cnt_d = rel_cnt_q;
        done_d    = done_q;
        if (tick && sync_q[1] && !done_q) begin
            if (rel_cnt_q == 8'(RST_CYCLES)) done_d = 1'b1;
            else                             rel_cnt_d = rel_cnt_q + 8'd1;
        end
    end

    // Stored as "done" so an all-zero power-up state already means reset asserted.
    assign reset = ~done_q;

    generate
        if (DIRECT) begin : g_direct
            assign clk  = CLK;
            assign tick = 1'b1;

            always_ff @(negedge CLK or negedge RESET) begin
                if (!RESET) begin
                    rel_cnt_q <= '0;
                    done_q    <= 1'b0;
                end else begin
                    // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
                    rel_cnt_q <= rel_cnt_d;
                    done_q    <= done_d;
                end
            end
        end else begin : g_div
            localparam int CW = SLOW;
            logic [CW-1:0] cnt_q, cnt_d;

            always_comb cnt_d = cnt_q + CW'(1);

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            // Straight from the flop bit: no logic between register and clock net.
            assign clk  = cnt_q[CW-1];
            assign tick = &cnt_q;

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    rel_cnt_q <= '0;
                    done_q    <= 1'b0;
                end else begin
                    rel_cnt_q <= rel_cnt_d;
                    done_q    <= done_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_clockworks.sv
// Directed bench for clockworks: four parameterisations share CLK and RESET.
module tb_clockworks;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic clk0, rst0, clk2, rst2, clk3, rst3, clk4, rst4;
    int   tests = 0;
    int   fails = 0;
    int   k;

    always #5 CLK = ~CLK;

    clockworks #(.SLOW(0), .RST_CYCLES(1))  u_d0 (.CLK(CLK), .RESET(RESET), .clk(clk0), .reset(rst0));
    clockworks #(.SLOW(2), .RST_CYCLES(4))  u_d2 (.CLK(CLK), .RESET(RESET), .clk(clk2), .reset(rst2));
    clockworks #(.SLOW(3), .RST_CYCLES(4))  u_d3 (.CLK(CLK), .RESET(RESET), .clk(clk3), .reset(rst3));
    clockworks #(.SLOW(4), .RST_CYCLES(16)) u_d4 (.CLK(CLK), .RESET(RESET), .clk(clk4), .reset(rst4));

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    // Expected clk at the sample point k CLK rising edges after RESET rose.
    function automatic logic exp_clk(input int s, input int kk);
`ifdef CLOCKWORKS_BYPASS_EN
        return 1'b1;
`else
        if (s == 0) return 1'b1;
        return logic'((kk >> (s - 1)) & 1);
`endif
    endfunction

    // Hand-derived release edges: released at edge 2, first tick aligns, then R full periods.
    // SLOW=2,R=4 -> edge 20; SLOW=3,R=4 -> edge 40; SLOW=4,R=16 -> edge 272;
    // SLOW=0,R=1 -> falling edge after rising edge 3, first seen at edge 4.
    function automatic logic exp_rst(input int s, input int kk);
`ifdef CLOCKWORKS_BYPASS_EN
        int r;
        r = (s == 0) ? 1 : (s == 4) ? 16 : 4;
        return logic'(kk < r + 3);
`else
        case (s)
            0:       return logic'(kk < 4);
            2:       return logic'(kk < 20);
            3:       return logic'(kk < 40);
            default: return logic'(kk < 272);
        endcase
`endif
    endfunction

    task automatic check_all();
        check("d0_clk", clk0, exp_clk(0, k));
        check("d0_rst", rst0, exp_rst(0, k));
        check("d2_clk", clk2, exp_clk(2, k));
        check("d2_rst", rst2, exp_rst(2, k));
        check("d3_clk", clk3, exp_clk(3, k));
        check("d3_rst", rst3, exp_rst(3, k));
        check("d4_clk", clk4, exp_clk(4, k));
        check("d4_rst", rst4, exp_rst(4, k));
    endtask

    // Advance one CLK, check just after the rising edge and again in the low phase.
    task automatic step();
        @(posedge CLK);
        k++;
        #2;
        check_all();
        #5;
        check("d0_clk_low", clk0, 1'b0);
    endtask

    initial begin
        k = 0;
        // Hold reset for 10 CLK: divided clocks low, every reset high.
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #2;
            check("hold_d2_clk", clk2, 1'b0);
            check("hold_d3_clk", clk3, 1'b0);
            check("hold_d4_clk", clk4, 1'b0);
            check("hold_rst0", rst0, 1'b1);
            check("hold_rst2", rst2, 1'b1);
            check("hold_rst3", rst3, 1'b1);
            check("hold_rst4", rst4, 1'b1);
        end
        #5;
        RESET = 1'b1;
        k = 0;
        for (int i = 0; i < 1000; i++) step();

        // Half-period glitch mid-operation.
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("glitch_rst0", rst0, 1'b1);
        check("glitch_rst2", rst2, 1'b1);
        check("glitch_rst3", rst3, 1'b1);
        check("glitch_rst4", rst4, 1'b1);
`ifndef CLOCKWORKS_BYPASS_EN
        check("glitch_clk2", clk2, 1'b0);
        check("glitch_clk3", clk3, 1'b0);
        check("glitch_clk4", clk4, 1'b0);
`endif
        #4;
        RESET = 1'b1;
        k = 0;
        for (int i = 0; i < 320; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
